// File: rtl/wave_dac_pkg.sv
// Shared definitions for the waveform DAC serialiser: FSM state encoding,
// frame width and the midscale/unity constants used by the scaler.
package wave_dac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  localparam int         FRAME_BITS = 16;
  localparam logic [7:0] SAMPLE_MID = 8'h80;
  localparam logic [4:0] UNITY_GAIN = 5'd16;

endpackage

// File: rtl/wave_dac_spi_if.sv
// Sample-side strobe plus DAC pins and status for wave_dac_spi.
// master = waveform source / observer, slave = the serialiser.
// The gain signal exists only when DAC_SCALE_EN is defined.
interface wave_dac_spi_if;

  logic [7:0] sample_in;
  logic       sample_valid;
`ifdef DAC_SCALE_EN
  logic [4:0] gain;
`endif
  logic       dac_cs_n;
  logic       dac_sclk;
  logic       dac_mosi;
  logic       busy;
  logic       frame_done;
  logic [7:0] drop_cnt;

`ifdef DAC_SCALE_EN
  modport master (
    output sample_in, sample_valid, gain,
    input  dac_cs_n, dac_sclk, dac_mosi, busy, frame_done, drop_cnt
  );
  modport slave (
    input  sample_in, sample_valid, gain,
    output dac_cs_n, dac_sclk, dac_mosi, busy, frame_done, drop_cnt
  );
`else
  modport master (
    output sample_in, sample_valid,
    input  dac_cs_n, dac_sclk, dac_mosi, busy, frame_done, drop_cnt
  );
  modport slave (
    input  sample_in, sample_valid,
    output dac_cs_n, dac_sclk, dac_mosi, busy, frame_done, drop_cnt
  );
`endif

endinterface

// File: rtl/wave_dac_scale.sv
// Combinational amplitude scaler around midscale.
// code = 128 + floor(((sample-128) * min(gain,16)) / 16).
// With gain clamped to unity the result always stays inside 0..255.
module wave_dac_scale
  import wave_dac_pkg::*;
(
  input  logic [7:0] sample_i,
  input  logic [4:0] gain_i,
  output logic [7:0] code_o
);

  logic signed [8:0]  diff;
  logic        [4:0]  g;
  logic signed [14:0] prod;
  logic signed [14:0] shifted;
  logic signed [14:0] sum;

  assign diff    = $signed({1'b0, sample_i}) - $signed({1'b0, SAMPLE_MID});
  assign g       = (gain_i > UNITY_GAIN) ? UNITY_GAIN : gain_i;
  assign prod    = 15'(diff) * 15'($signed({1'b0, g}));
  // Arithmetic shift gives floor division for negative offsets.
  assign shifted = prod >>> 4;
  assign sum     = shifted + 15'($signed({1'b0, SAMPLE_MID}));
  assign code_o  = 8'(sum);

endmodule

// File: rtl/wave_dac_spi.sv
// Serialises 8-bit waveform samples into {CTRL_WORD, code, PAD zeros} SPI
// frames for a serial DAC. The source cannot stall, so a one-deep pending
// slot absorbs a sample arriving mid-frame; overwrites are counted.
// Optional feature macro: DAC_SCALE_EN (adds gain input and scaler).
module wave_dac_spi
  import wave_dac_pkg::*;
#(
  parameter int         CLK_DIV   = 4,
  parameter logic [3:0] CTRL_WORD = 4'b0011,
  parameter int         PAD_BITS  = 4
)(
  input  logic          clk,
  input  logic          rst,
  wave_dac_spi_if.slave bus
);

  localparam int FW = 4 + 8 + PAD_BITS;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(FW);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(FW - 1);

  state_t        state_q;
  logic [FW-1:0] shift_q;
  logic [DW-1:0] div_q;
  logic [BW-1:0] bit_q;
  logic          cs_n_q, sclk_q, mosi_q, busy_q, frame_done_q;
  logic [7:0]    pend_q;
  logic          pend_full_q;
  logic [7:0]    drop_q;

  logic [7:0]    code_d;
  logic          hold_last_d;
  logic          start_d;
  logic [7:0]    start_code_d;
  logic [FW-1:0] frame_d;

`ifdef DAC_SCALE_EN
  wave_dac_scale u_scale (
    .sample_i (bus.sample_in),
    .gain_i   (bus.gain),
    .code_o   (code_d)
  );
`else
  assign code_d = bus.sample_in;
`endif

  // Frame start decision: fresh capture in IDLE, or chaining out of the
  // final HOLD cycle from the pending slot (priority) or a same-cycle strobe.
  always_comb begin
    hold_last_d  = (state_q == ST_HOLD) && (div_q == DIV_LAST);
    start_d      = ((state_q == ST_IDLE) && bus.sample_valid) ||
                   (hold_last_d && (pend_full_q || bus.sample_valid));
    start_code_d = (hold_last_d && pend_full_q) ? pend_q : code_d;
    frame_d      = {CTRL_WORD, start_code_d, {PAD_BITS{1'b0}}};
  end

  // FSM, SCLK divider, bit counter, shift register, pending slot and drop counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      shift_q      <= '0;
      div_q        <= '0;
      bit_q        <= '0;
      cs_n_q       <= 1'b1;
      sclk_q       <= 1'b0;
      mosi_q       <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      pend_q       <= '0;
      pend_full_q  <= 1'b0;
      drop_q       <= '0;
    end else begin
      frame_done_q <= 1'b0;

      // Pending slot: drained on HOLD->LOAD and refilled by a same-cycle
      // strobe without counting a drop; otherwise a busy strobe overwrites.
      if (hold_last_d) begin
        if (pend_full_q) begin
          pend_full_q <= bus.sample_valid;
          if (bus.sample_valid) pend_q <= code_d;
        end
      end else if ((state_q != ST_IDLE) && bus.sample_valid) begin
        pend_q      <= code_d;
        pend_full_q <= 1'b1;
        if (pend_full_q && (drop_q != 8'hFF)) drop_q <= drop_q + 8'd1;
      end

      if (start_d) begin
        state_q <= ST_LOAD;
        shift_q <= frame_d;
        mosi_q  <= frame_d[FW-1];
        cs_n_q  <= 1'b0;
        sclk_q  <= 1'b0;
        busy_q  <= 1'b1;
        div_q   <= '0;
        bit_q   <= '0;
      end else begin
        case (state_q)
          ST_IDLE: ;
          // LOAD counts as the first cycle of bit 15's low phase.
          ST_LOAD, ST_SHIFT: begin
            state_q <= ST_SHIFT;
            if (div_q == DIV_LAST) begin
              div_q <= '0;
              if (!sclk_q) begin
                sclk_q <= 1'b1;
              end else if (bit_q == BIT_LAST) begin
                state_q      <= ST_HOLD;
                cs_n_q       <= 1'b1;
                sclk_q       <= 1'b0;
                mosi_q       <= 1'b0;
                frame_done_q <= (CLK_DIV == 1);
              end else begin
                sclk_q  <= 1'b0;
                shift_q <= shift_q << 1;
                mosi_q  <= shift_q[FW-2];
                bit_q   <= bit_q + 1'b1;
              end
            end else begin
              div_q <= div_q + 1'b1;
            end
          end
          ST_HOLD: begin
            if (hold_last_d) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else begin
              div_q        <= div_q + 1'b1;
              frame_done_q <= ((int'(div_q) + 1) == (CLK_DIV - 1));
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.dac_cs_n   = cs_n_q;
  assign bus.dac_sclk   = sclk_q;
  assign bus.dac_mosi   = mosi_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;
  assign bus.drop_cnt   = drop_q;

endmodule
